sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-master, one-slave SRAM-like bus arbiter between the instruction-fetch and data-access ports of the five-stage core and a single shared memory port. It accepts one request at a time from IF (read-only) or EX/MEM (read/write), forwards it downstream, and routes the response back to its owner. It also supports cancelling an in-flight fetch on pipeline flush. It sits between the core top and the external bridge.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  flush: drop pending/incoming fetch
- inst_addr_ok  out  1  fetch accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store done
- data_rdata  out  DATA_W  load data
- mem_req, mem_wr, mem_size[2], mem_wstrb[4], mem_addr[ADDR_W], mem_wdata[DATA_W]  out  downstream request
- mem_addr_ok, mem_data_ok  in  1  downstream handshakes
- mem_rdata  in  DATA_W  downstream read data

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register: INST or DATA. Request buffer: wr, size, wstrb, addr, wdata. Cancelled flag.
- IDLE: if any request is eligible, pick a winner, latch its fields into the buffer, assert its x_addr_ok combinationally this cycle, and go to ADDR. A fetch is eligible only when inst_req=1 and inst_cancel=0.
- Fetch is latched as wr=0, size=2, wstrb=0, wdata=0.
- ADDR: mem_req=1 with buffered fields held stable. On mem_addr_ok, go to DATA.
- DATA: mem_req=0. On mem_data_ok:
  - x_data_ok=owner match & ~cancelled, combinationally.
  - rdata passes through from mem_rdata.
  - Go to IDLE.
- Non-owner data_ok is always 0. inst_rdata and data_rdata both pass mem_rdata through; only the data_ok outputs qualify them.
- inst_cancel with owner=INST in ADDR or DATA sets cancelled. The transaction still completes downstream; its inst_data_ok is suppressed. Cancelled clears on return to IDLE.
- inst_cancel is ignored when owner=DATA.
- Default priority: data over inst when both are eligible.

## Timing
- Reset: state IDLE, owner INST, cancelled=0, buffer 0. All outputs are 0 except the rdata pass-throughs.
- Minimum latency is 3 cycles (assuming mem_addr_ok immediate, mem_data_ok next):
  - Cycle 0: accept (x_addr_ok).
  - Cycle 1: mem_req and mem_addr_ok.
  - Cycle 2: mem_data_ok and x_data_ok.
- Next accept is no earlier than cycle 3. At most one transaction is outstanding.
- mem_addr_ok and mem_data_ok are ignored outside ADDR and DATA respectively.
- Reset mid-transaction returns to IDLE and drops the owner and response. The downstream slave is reset in the same cycle.
- inst_cancel and mem_data_ok in the same cycle: the response is suppressed.
- inst_req with inst_cancel in IDLE: not accepted. data_req may still win in that cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin priority.
  - A last-grant bit updates on each accept.
  - On simultaneous eligible requests, the master not granted last wins. Single requests win immediately.
  - The last-grant bit resets to INST, so data wins the first tie.
- Undefined: fixed priority, data always wins ties, no last-grant state.

## Structure
- Package sram_arb_pkg:
  - State enum (IDLE/ADDR/DATA).
  - Owner encoding (OWN_INST=0, OWN_DATA=1).
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
- One sub-module, sram_arb_sel: winner selection (fixed or round-robin), combinational plus the optional last-grant flop.

## Test plan
- Lone fetch, addr 0x1C000000, slave returns 0x02800C0C after 1 cycle -> inst_addr_ok cycle 0, mem_req cycle 1, inst_data_ok with rdata 0x02800C0C cycle 2, data_data_ok stays 0.
- Store, addr 0x8000_0010, size=2, wstrb=0xF, wdata=0xDEADBEEF -> mem_wr=1 with identical fields held through 3 cycles of mem_addr_ok=0, data_data_ok on response.
- data_req and inst_req in the same cycle, both held across repeated transactions:
  - Fixed mode: data granted every time.
  - RR mode: grants alternate DATA, INST, DATA.
- Fetch accepted, inst_cancel pulsed in DATA -> mem transaction completes, inst_data_ok stays 0. Next fetch returns normally.
- inst_req with inst_cancel in IDLE, no data_req -> no inst_addr_ok, stays IDLE, mem_req 0.
- reset asserted in ADDR -> next cycle IDLE, mem_req 0, all ok outputs 0. A fresh fetch afterwards completes in 3 cycles.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM-like bus arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_if.sv
// SRAM-like request/response bus. The master drives the request fields;
// the slave returns the address/data handshakes and read data.
interface sram_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_arb_sel.sv
// Winner selection between the fetch and data masters.
// SRAM_ARB_RR_EN selects round-robin tie-breaking; otherwise data always wins ties.
module sram_arb_sel
    import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic accept,
`endif
    input  logic inst_elig,
    input  logic data_elig,
    output logic grant_valid,
    output logic grant_data
);

    assign grant_valid = inst_elig | data_elig;

`ifdef SRAM_ARB_RR_EN
    logic last_grant_reg;
    logic last_grant_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= OWN_INST;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant_reg;
        if (accept) begin
            last_grant_next = grant_data ? OWN_DATA : OWN_INST;
        end
    end

    // On a tie, the master that was not granted last takes the bus.
    assign grant_data = data_elig & (~inst_elig | (last_grant_reg == OWN_INST));
`else
    assign grant_data = data_elig;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-master, one-slave SRAM-like arbiter with fetch cancel on flush.
// Define SRAM_ARB_RR_EN for round-robin arbitration (default: data has priority).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_cancel,
    sram_arb_if.slave   inst,
    sram_arb_if.slave   data,
    sram_arb_if.master  mem
);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              cancelled_reg, cancelled_next;
    logic              rq_wr_reg, rq_wr_next;
    logic [1:0]        rq_size_reg, rq_size_next;
    logic [3:0]        rq_wstrb_reg, rq_wstrb_next;
    logic [ADDR_W-1:0] rq_addr_reg, rq_addr_next;
    logic [DATA_W-1:0] rq_wdata_reg, rq_wdata_next;

    logic inst_elig;
    logic data_elig;
    logic grant_valid;
    logic grant_data;
    logic accept;

    assign inst_elig = inst.req & ~inst_cancel;
    assign data_elig = data.req;

    sram_arb_sel u_sel (
`ifdef SRAM_ARB_RR_EN
        .clk         (clk),
        .reset       (reset),
        .accept      (accept),
`endif
        .inst_elig   (inst_elig),
        .data_elig   (data_elig),
        .grant_valid (grant_valid),
        .grant_data  (grant_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_INST;
            cancelled_reg <= 1'b0;
            rq_wr_reg     <= 1'b0;
            rq_size_reg   <= 2'd0;
            rq_wstrb_reg  <= 4'd0;
            rq_addr_reg   <= '0;
            rq_wdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            cancelled_reg <= cancelled_next;
            rq_wr_reg     <= rq_wr_next;
            rq_size_reg   <= rq_size_next;
            rq_wstrb_reg  <= rq_wstrb_next;
            rq_addr_reg   <= rq_addr_next;
            rq_wdata_reg  <= rq_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        cancelled_next = cancelled_reg;
        rq_wr_next     = rq_wr_reg;
        rq_size_next   = rq_size_reg;
        rq_wstrb_next  = rq_wstrb_reg;
        rq_addr_next   = rq_addr_reg;
        rq_wdata_next  = rq_wdata_reg;
        accept         = 1'b0;
        inst.addr_ok   = 1'b0;
        inst.data_ok   = 1'b0;
        data.addr_ok   = 1'b0;
        data.data_ok   = 1'b0;
        mem.req        = 1'b0;

        case (state_reg)
            IDLE: begin
                cancelled_next = 1'b0;
                if (grant_valid) begin
                    accept     = 1'b1;
                    state_next = ADDR;
                    if (grant_data) begin
                        owner_next    = OWN_DATA;
                        data.addr_ok  = 1'b1;
                        rq_wr_next    = data.wr;
                        rq_size_next  = data.size;
                        rq_wstrb_next = data.wstrb;
                        rq_addr_next  = data.addr;
                        rq_wdata_next = data.wdata;
                    end else begin
                        owner_next    = OWN_INST;
                        inst.addr_ok  = 1'b1;
                        rq_wr_next    = 1'b0;
                        rq_size_next  = SIZE_WORD;
                        rq_wstrb_next = 4'd0;
                        rq_addr_next  = inst.addr;
                        rq_wdata_next = '0;
                    end
                end
            end
            ADDR: begin
                mem.req = 1'b1;
                if (inst_cancel && owner_reg == OWN_INST) begin
                    cancelled_next = 1'b1;
                end
                if (mem.addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (inst_cancel && owner_reg == OWN_INST) begin
                    cancelled_next = 1'b1;
                end
                if (mem.data_ok) begin
                    // A flush arriving with the response still kills it.
                    if (owner_reg == OWN_DATA) begin
                        data.data_ok = 1'b1;
                    end else begin
                        inst.data_ok = ~cancelled_reg & ~inst_cancel;
                    end
                    state_next     = IDLE;
                    cancelled_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Keep every handshake quiet while reset is held.
        if (reset) begin
            accept       = 1'b0;
            inst.addr_ok = 1'b0;
            inst.data_ok = 1'b0;
            data.addr_ok = 1'b0;
            data.data_ok = 1'b0;
            mem.req      = 1'b0;
        end
    end

    assign mem.wr    = rq_wr_reg;
    assign mem.size  = rq_size_reg;
    assign mem.wstrb = rq_wstrb_reg;
    assign mem.addr  = rq_addr_reg;
    assign mem.wdata = rq_wdata_reg;

    assign inst.rdata = mem.rdata;
    assign data.rdata = mem.rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (fixed or SRAM_ARB_RR_EN build).
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic inst_cancel;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] tie_exp;

    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) inst_bus ();
    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) data_bus ();
    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_cancel (inst_cancel),
        .inst        (inst_bus),
        .data        (data_bus),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_cancel      = 1'b0;
        inst_bus.req     = 1'b0;
        inst_bus.wr      = 1'b0;
        inst_bus.size    = SIZE_WORD;
        inst_bus.wstrb   = 4'd0;
        inst_bus.addr    = '0;
        inst_bus.wdata   = '0;
        data_bus.req     = 1'b0;
        data_bus.wr      = 1'b0;
        data_bus.size    = SIZE_WORD;
        data_bus.wstrb   = 4'd0;
        data_bus.addr    = '0;
        data_bus.wdata   = '0;
        mem_bus.addr_ok  = 1'b0;
        mem_bus.data_ok  = 1'b0;
        mem_bus.rdata    = '0;
    endtask

    // Fetch through the minimum-latency path: accept, address, data.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); clear_inputs(); inst_bus.req = 1'b1; inst_bus.addr = a;
        #1; chk({tag, "_aok"}, inst_bus.addr_ok, 1'b1);
        @(negedge clk); inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        #1; chk({tag, "_memreq"}, mem_bus.req, 1'b1);
        chk({tag, "_memaddr"}, mem_bus.addr, a);
        @(negedge clk); mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = d;
        #1; chk({tag, "_dok"}, inst_bus.data_ok, 1'b1);
        chk({tag, "_rdata"}, inst_bus.rdata, d);
        chk({tag, "_ddok"}, data_bus.data_ok, 1'b0);
        $display("txn %s: fetch addr=%h rdata=%h", tag, a, inst_bus.rdata);
        @(negedge clk); clear_inputs();
        #1; chk({tag, "_idle"}, mem_bus.req, 1'b0);
    endtask

    initial begin
`ifdef SRAM_ARB_RR_EN
        tie_exp = 3'b101;
`else
        tie_exp = 3'b111;
`endif
        // Reset with both requests pending: nothing may be accepted.
        clear_inputs();
        reset = 1'b1;
        inst_bus.req = 1'b1;
        data_bus.req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_aok", inst_bus.addr_ok, 1'b0);
        chk("rst_data_aok", data_bus.addr_ok, 1'b0);
        chk("rst_memreq", mem_bus.req, 1'b0);
        chk("rst_memaddr", mem_bus.addr, 32'h0);
        chk("rst_memwr", mem_bus.wr, 1'b0);
        $display("txn reset: outputs idle");
        @(negedge clk); reset = 1'b0; clear_inputs();

        // Lone fetch.
        fetch("fetch1", 32'h1C00_0000, 32'h0280_0C0C);

        // Store with stalled address phase; buffered fields must hold.
        @(negedge clk); data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = SIZE_WORD;
        data_bus.wstrb = 4'hF; data_bus.addr = 32'h8000_0010; data_bus.wdata = 32'hDEAD_BEEF;
        #1; chk("st_aok", data_bus.addr_ok, 1'b1);
        chk("st_inst_aok", inst_bus.addr_ok, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clear_inputs(); data_bus.wdata = 32'h1111_1111 * c;
            #1; chk("st_hold_req", mem_bus.req, 1'b1);
            chk("st_hold_wr", mem_bus.wr, 1'b1);
            chk("st_hold_addr", mem_bus.addr, 32'h8000_0010);
            chk("st_hold_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
            chk("st_hold_wstrb", mem_bus.wstrb, 4'hF);
            chk("st_hold_size", mem_bus.size, SIZE_WORD);
        end
        @(negedge clk); mem_bus.addr_ok = 1'b1;
        #1; chk("st_memreq", mem_bus.req, 1'b1);
        @(negedge clk); mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        #1; chk("st_dok", data_bus.data_ok, 1'b1);
        chk("st_idok", inst_bus.data_ok, 1'b0);
        $display("txn store: addr=80000010 wdata=deadbeef done=%0b", data_bus.data_ok);
        @(negedge clk); clear_inputs();

        // Fresh reset so the round-robin history starts at INST.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        // Both masters held requesting across three transactions.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); clear_inputs();
            data_bus.req = 1'b1; data_bus.addr = 32'h8000_0100 + 32'(t * 4);
            inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0100;
            #1; chk("tie_data_aok", data_bus.addr_ok, tie_exp[t]);
            chk("tie_inst_aok", inst_bus.addr_ok, !tie_exp[t]);
            @(negedge clk); mem_bus.addr_ok = 1'b1;
            #1; chk("tie_memaddr", mem_bus.addr,
                    tie_exp[t] ? 32'h8000_0100 + 32'(t * 4) : 32'h1C00_0100);
            @(negedge clk); mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'(t);
            #1; chk("tie_data_dok", data_bus.data_ok, tie_exp[t]);
            chk("tie_inst_dok", inst_bus.data_ok, !tie_exp[t]);
            $display("txn tie%0d: winner=%s", t, data_bus.data_ok ? "DATA" : "INST");
        end
        @(negedge clk); clear_inputs();

        // Fetch cancelled while waiting for data.
        @(negedge clk); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0040;
        #1; chk("cx_aok", inst_bus.addr_ok, 1'b1);
        @(negedge clk); clear_inputs(); mem_bus.addr_ok = 1'b1;
        @(negedge clk); clear_inputs(); inst_cancel = 1'b1;
        #1; chk("cx_dok_wait", inst_bus.data_ok, 1'b0);
        @(negedge clk); clear_inputs(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hAAAA_5555;
        #1; chk("cx_dok", inst_bus.data_ok, 1'b0);
        chk("cx_memreq", mem_bus.req, 1'b0);
        $display("txn cancel: fetch 1c000040 response dropped");
        fetch("fetch2", 32'h1C00_0044, 32'h1234_5678);

        // Cancel arriving together with the response.
        @(negedge clk); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0080;
        @(negedge clk); clear_inputs(); mem_bus.addr_ok = 1'b1;
        @(negedge clk); clear_inputs(); mem_bus.data_ok = 1'b1; inst_cancel = 1'b1;
        #1; chk("cx_same_dok", inst_bus.data_ok, 1'b0);
        $display("txn cancel_same_cycle: response dropped");
        @(negedge clk); clear_inputs();

        // Fetch request with cancel in IDLE is not eligible.
        @(negedge clk); inst_bus.req = 1'b1; inst_cancel = 1'b1; inst_bus.addr = 32'h1C00_00C0;
        #1; chk("idle_cx_aok", inst_bus.addr_ok, 1'b0);
        @(negedge clk); clear_inputs();
        #1; chk("idle_cx_memreq", mem_bus.req, 1'b0);
        $display("txn idle_cancel: not accepted");

        // Reset while in the address phase.
        @(negedge clk); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0100;
        #1; chk("rstx_aok", inst_bus.addr_ok, 1'b1);
        @(negedge clk); clear_inputs(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1; chk("rstx_memreq", mem_bus.req, 1'b0);
        chk("rstx_inst_dok", inst_bus.data_ok, 1'b0);
        chk("rstx_data_dok", data_bus.data_ok, 1'b0);
        $display("txn reset_in_addr: back to idle");
        fetch("fetch3", 32'h1C00_0200, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
